// File: rtl/reg_loader_pkg.sv
// Shared types and default sizing for the register file boot loader.
package reg_loader_pkg;

    localparam int NUM_REGS_DEF   = 32;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 5;

    // Loader phases. IDLE encodes as 0 so a reset state reads back as all-zero.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_VERIFY = 3'd3,
        ST_DONE   = 3'd4
    } load_state_t;

endpackage

// File: rtl/load_checksum.sv
// Modulo-2^DATA_WIDTH running sum with synchronous clear and add enable.
// Clear has priority over add so a start cycle always begins from zero.
module load_checksum #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  add_en,
    input  logic [DATA_WIDTH-1:0] add_value,
    output logic [DATA_WIDTH-1:0] sum
);

    // Accumulate; carries out of the top bit are intentionally dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (add_en) begin
            sum <= sum + add_value;
        end
    end

endmodule

// File: rtl/reg_file_loader.sv
// Boot-time loader for the register file: streams words into registers
// 0..NUM_REGS-1 through the write port, then reads them all back through
// read port 1 and compares write-side and read-side checksums.
//
// Handshake: a beat transfers on a rising edge where Load_Valid and
// Load_Ready are both high; Load_Ready is high exactly while in LOAD, and
// Load_Data is only looked at on a transferring edge.
module reg_file_loader
    import reg_loader_pkg::*;
#(
    parameter int NUM_REGS   = NUM_REGS_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Load_Start,
    input  logic [DATA_WIDTH-1:0] Load_Data,
    input  logic                  Load_Valid,
    output logic                  Load_Ready,
    output logic [ADDR_WIDTH-1:0] Write_Register,
    output logic [DATA_WIDTH-1:0] Write_Data,
    output logic                  Reg_Write,
    output logic [ADDR_WIDTH-1:0] Read_Register_1,
    input  logic [DATA_WIDTH-1:0] Read_Data_1,
    output logic                  Load_Busy,
    output logic                  Load_Done,
    output logic                  Load_Error,
    output load_state_t           Load_State
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

    load_state_t           state;
    logic [ADDR_WIDTH-1:0] index;
    logic [DATA_WIDTH-1:0] wr_sum;
    logic [DATA_WIDTH-1:0] rd_sum;
    logic [DATA_WIDTH-1:0] rd_sum_final;
    logic                  start_ok;
    logic                  beat;
    logic                  verify_en;

    // Start is only honoured when no load is in flight.
    assign start_ok  = Load_Start && ((state == ST_IDLE) || (state == ST_DONE));
    assign beat      = Load_Valid && Load_Ready;
    assign verify_en = (state == ST_VERIFY);

    // Read-side sum including the word being read this cycle, so the last
    // comparison covers every register.
    assign rd_sum_final = rd_sum + Read_Data_1;

    assign Read_Register_1 = verify_en ? index : '0;
    assign Load_State      = state;

    load_checksum #(.DATA_WIDTH(DATA_WIDTH)) u_wr_sum (
        .clk       (clk),
        .reset     (reset),
        .clear     (start_ok),
        .add_en    (beat),
        .add_value (Load_Data),
        .sum       (wr_sum)
    );

    load_checksum #(.DATA_WIDTH(DATA_WIDTH)) u_rd_sum (
        .clk       (clk),
        .reset     (reset),
        .clear     (start_ok),
        .add_en    (verify_en),
        .add_value (Read_Data_1),
        .sum       (rd_sum)
    );

    // Loader FSM with index counter and registered write-port / status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            index          <= '0;
            Load_Ready     <= 1'b0;
            Write_Register <= '0;
            Write_Data     <= '0;
            Reg_Write      <= 1'b0;
            Load_Busy      <= 1'b0;
            Load_Done      <= 1'b0;
            Load_Error     <= 1'b0;
        end else begin
            // Write enable is a single-cycle pulse following an accepted beat.
            Reg_Write <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (Load_Start) begin
                        state      <= ST_LOAD;
                        index      <= '0;
                        Load_Ready <= 1'b1;
                        Load_Busy  <= 1'b1;
                        Load_Done  <= 1'b0;
                        Load_Error <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (Load_Valid) begin
                        Write_Data     <= Load_Data;
                        Write_Register <= index;
                        Reg_Write      <= 1'b1;
                        index          <= index + 1'b1;
                        if (index == LAST_IDX) begin
                            state      <= ST_DRAIN;
                            Load_Ready <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Final write commits on this edge; readback starts at 0.
                    index <= '0;
                    state <= ST_VERIFY;
                end
                ST_VERIFY: begin
                    index <= index + 1'b1;
                    if (index == LAST_IDX) begin
                        state      <= ST_DONE;
                        Load_Busy  <= 1'b0;
                        Load_Done  <= 1'b1;
                        Load_Error <= (rd_sum_final != wr_sum);
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    Load_Ready <= 1'b0;
                    Load_Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_loader.sv
// Directed bench for reg_file_loader with a behavioural 32x32 register file.
module tb_reg_file_loader;
    import reg_loader_pkg::*;

    localparam int N  = 32;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          Load_Start = 1'b0;
    logic [DW-1:0] Load_Data = '0;
    logic          Load_Valid = 1'b0;
    logic          Load_Ready;
    logic [AW-1:0] Write_Register;
    logic [DW-1:0] Write_Data;
    logic          Reg_Write;
    logic [AW-1:0] Read_Register_1;
    logic [DW-1:0] Read_Data_1;
    logic          Load_Busy;
    logic          Load_Done;
    logic          Load_Error;
    load_state_t   Load_State;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;

    // Register file model plus a bench-side write path for corruption tests.
    logic [DW-1:0] regs [N];
    logic          mem_clear = 1'b0;
    logic          frc_en = 1'b0;
    logic [AW-1:0] frc_addr = '0;
    logic [DW-1:0] frc_data = '0;

    logic [DW-1:0]    exp_mem [N];
    logic [AW+DW-1:0] exp_q[$];

    typedef struct {
        string name;
        int    gap;
        int    dmode;
        bit    frc;
        bit    spur;
        int    exp_done;
        bit    exp_err;
    } vec_t;
    vec_t vecs [4];

    // clock / reset block
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < N; i++) regs[i] <= '0;
        end else begin
            if (Reg_Write) regs[Write_Register] <= Write_Data;
            if (frc_en) regs[frc_addr] <= frc_data;
        end
    end

    assign Read_Data_1 = regs[Read_Register_1];

    reg_file_loader #(.NUM_REGS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk             (clk),
        .reset           (reset),
        .Load_Start      (Load_Start),
        .Load_Data       (Load_Data),
        .Load_Valid      (Load_Valid),
        .Load_Ready      (Load_Ready),
        .Write_Register  (Write_Register),
        .Write_Data      (Write_Data),
        .Reg_Write       (Reg_Write),
        .Read_Register_1 (Read_Register_1),
        .Read_Data_1     (Read_Data_1),
        .Load_Busy       (Load_Busy),
        .Load_Done       (Load_Done),
        .Load_Error      (Load_Error),
        .Load_State      (Load_State)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ready"}, 64'(Load_Ready), 64'd0);
        chk({tag, "_wreg"}, 64'(Write_Register), 64'd0);
        chk({tag, "_wdata"}, 64'(Write_Data), 64'd0);
        chk({tag, "_regwrite"}, 64'(Reg_Write), 64'd0);
        chk({tag, "_rreg"}, 64'(Read_Register_1), 64'd0);
        chk({tag, "_busy"}, 64'(Load_Busy), 64'd0);
        chk({tag, "_done"}, 64'(Load_Done), 64'd0);
        chk({tag, "_error"}, 64'(Load_Error), 64'd0);
        chk({tag, "_state"}, 64'(Load_State), 64'(ST_IDLE));
    endtask

    function automatic logic [DW-1:0] word(input int m, input int i);
        case (m)
            0:       return 32'h1000_0000 + 32'(i);
            1:       return 32'hFFFF_FFFF;
            default: return (32'(i) * 32'h0101_0101) ^ 32'hA5A5_A5A5;
        endcase
    endfunction

    // Driver + checker for one complete load; called at a negedge.
    task automatic run_load(input vec_t v);
        int            idx = 0;
        int            cyc = 0;
        int            vi = 0;
        int            start_edge;
        bit            prev_beat = 1'b0;
        bit            beat;
        logic [DW-1:0] d;
        logic [AW+DW-1:0] e;

        // A word offered on the start edge itself must not be taken.
        Load_Start = 1'b1;
        Load_Valid = 1'b1;
        Load_Data  = 32'hBAD0_0001;
        start_edge = edge_cnt + 1;
        @(negedge clk);
        Load_Start = 1'b0;
        chk({v.name, "_entry_done_clr"}, 64'(Load_Done), 64'd0);
        chk({v.name, "_entry_err_clr"}, 64'(Load_Error), 64'd0);

        while (idx < N && cyc < 200) begin
            chk({v.name, "_ready"}, 64'(Load_Ready), 64'd1);
            chk({v.name, "_busy"}, 64'(Load_Busy), 64'd1);
            chk({v.name, "_regwrite"}, 64'(Reg_Write), 64'(prev_beat));
            if (prev_beat && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({v.name, "_wreg"}, 64'(Write_Register), 64'(e[AW+DW-1:DW]));
                chk({v.name, "_wdata"}, 64'(Write_Data), 64'(e[DW-1:0]));
            end
            beat = (v.gap == 0) || (cyc % 2 == 0);
            d = word(v.dmode, idx);
            Load_Start = v.spur && (cyc == 5);
            Load_Valid = beat;
            Load_Data  = beat ? d : (32'hBAD0_0100 + 32'(cyc));
            if (beat) begin
                exp_q.push_back({idx[AW-1:0], d});
                exp_mem[idx] = d;
                idx++;
            end
            prev_beat = beat;
            cyc++;
            @(negedge clk);
        end
        Load_Start = 1'b0;

        // DRAIN cycle: last write presented, no longer ready.
        Load_Valid = 1'b1;
        Load_Data  = 32'hBAD0_0002;
        chk({v.name, "_drain_ready"}, 64'(Load_Ready), 64'd0);
        chk({v.name, "_drain_busy"}, 64'(Load_Busy), 64'd1);
        chk({v.name, "_drain_regwrite"}, 64'(Reg_Write), 64'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({v.name, "_drain_wreg"}, 64'(Write_Register), 64'(e[AW+DW-1:DW]));
            chk({v.name, "_drain_wdata"}, 64'(Write_Data), 64'(e[DW-1:0]));
        end
        chk({v.name, "_drain_state"}, 64'(Load_State), 64'(ST_DRAIN));
        if (v.frc) begin
            frc_en   = 1'b1;
            frc_addr = 5'd7;
            frc_data = 32'hDEAD_BEEF;
            exp_mem[7] = 32'hDEAD_BEEF;
        end
        @(negedge clk);
        frc_en = 1'b0;
        Load_Valid = 1'b0;

        // VERIFY: one readback per cycle, no writes.
        while (!Load_Done && vi < N + 5) begin
            chk({v.name, "_verify_rreg"}, 64'(Read_Register_1), 64'(vi));
            chk({v.name, "_verify_regwrite"}, 64'(Reg_Write), 64'd0);
            chk({v.name, "_verify_busy"}, 64'(Load_Busy), 64'd1);
            Load_Start = v.spur && (vi == 10);
            @(negedge clk);
            vi++;
        end
        Load_Start = 1'b0;

        chk({v.name, "_verify_cycles"}, 64'(vi), 64'(N));
        chk({v.name, "_done"}, 64'(Load_Done), 64'd1);
        chk({v.name, "_done_edge"}, 64'(edge_cnt - start_edge), 64'(v.exp_done));
        chk({v.name, "_done_busy"}, 64'(Load_Busy), 64'd0);
        chk({v.name, "_done_rreg"}, 64'(Read_Register_1), 64'd0);
        chk({v.name, "_error"}, 64'(Load_Error), 64'(v.exp_err));
        chk({v.name, "_state"}, 64'(Load_State), 64'(ST_DONE));
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s_reg%0d", v.name, i), 64'(regs[i]), 64'(exp_mem[i]));
        end
        // Sticky flags hold while idle in DONE.
        @(negedge clk);
        chk({v.name, "_done_hold"}, 64'(Load_Done), 64'd1);
        chk({v.name, "_error_hold"}, 64'(Load_Error), 64'(v.exp_err));
    endtask

    initial begin
        vecs[0] = '{name: "cont_inc", gap: 0, dmode: 0, frc: 1'b0, spur: 1'b0, exp_done: 65, exp_err: 1'b0};
        vecs[1] = '{name: "force_r7", gap: 0, dmode: 2, frc: 1'b1, spur: 1'b0, exp_done: 65, exp_err: 1'b1};
        vecs[2] = '{name: "gap_inc",  gap: 1, dmode: 0, frc: 1'b0, spur: 1'b0, exp_done: 96, exp_err: 1'b0};
        vecs[3] = '{name: "all_ones", gap: 0, dmode: 1, frc: 1'b0, spur: 1'b1, exp_done: 65, exp_err: 1'b0};

        // Reset with register file cleared.
        mem_clear = 1'b1;
        for (int i = 0; i < N; i++) exp_mem[i] = '0;
        @(negedge clk);
        @(negedge clk);
        chk_outputs_zero("reset");
        reset = 1'b1;
        mem_clear = 1'b0;
        @(negedge clk);
        chk_outputs_zero("post_reset");

        // Reset in the middle of a load after five beats.
        Load_Start = 1'b1;
        @(negedge clk);
        Load_Start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            Load_Valid = 1'b1;
            Load_Data  = 32'h5A00_0000 + 32'(i);
            exp_mem[i] = Load_Data;
            @(negedge clk);
        end
        Load_Valid = 1'b0;
        chk("midrst_last_write_en", 64'(Reg_Write), 64'd1);
        chk("midrst_last_write_reg", 64'(Write_Register), 64'd4);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 chk_outputs_zero("midrst");
        Load_Valid = 1'b1;
        Load_Data  = 32'hBAD0_0003;
        @(negedge clk);
        @(negedge clk);
        chk_outputs_zero("midrst_hold");
        for (int i = 0; i < N; i++) begin
            chk($sformatf("midrst_reg%0d", i), 64'(regs[i]), 64'(exp_mem[i]));
        end
        Load_Valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk_outputs_zero("midrst_release");

        // Table-driven loads; each after the first restarts from DONE.
        for (int k = 0; k < 4; k++) begin
            run_load(vecs[k]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound in case a wait never resolves.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
